ws2812_frame_streamer: RTL and testbench

Parametrised WS2812/NeoPixel serial driver that streams a full frame of 24-bit GRB pixels from an external pixel source, typically a synchronous frame-buffer RAM, onto a single data line. It succeeds the fixed 64-LED, on/off-only driver:
- LED count, bit timing and latch time are parameters.
- Per-pixel colour comes from a fetch interface.
- A global brightness scale is applied to every channel.
- One-shot and continuous refresh modes are supported.

It sits between the game/render logic, which owns the pixel store, and the `uo_out` pin.

---
 rtl/ws2812_pkg.sv | 44 ++++
 rtl/ws2812_bit_encoder.sv | 48 ++++
 rtl/ws2812_frame_streamer.sv | 159 +++++++++++++++
 tb/tb_ws2812_frame_streamer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame streamer: FSM states, GRB layout,
// default timing for common clocks and the brightness scaling helpers.
package ws2812_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_WAIT,
        ST_SEND,
        ST_LATCH
    } state_t;

    localparam int unsigned G_LSB = 16;
    localparam int unsigned R_LSB = 8;
    localparam int unsigned B_LSB = 0;

    // 50 MHz: 400 ns / 800 ns highs, 1.26 us cell, 60 us latch
    localparam int unsigned T0H_50M    = 20;
    localparam int unsigned T1H_50M    = 40;
    localparam int unsigned TBIT_50M   = 63;
    localparam int unsigned TRESET_50M = 3000;

    localparam int unsigned T0H_25M    = 10;
    localparam int unsigned T1H_25M    = 20;
    localparam int unsigned TBIT_25M   = 32;
    localparam int unsigned TRESET_25M = 1500;

    // (c * (b + 1)) >> 8: b = 255 passes c through unchanged, b = 0 yields 0
    function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] px, input logic [7:0] b);
        logic [23:0] res;
        res = '0;
        res[G_LSB +: 8] = scale_channel(px[G_LSB +: 8], b);
        res[R_LSB +: 8] = scale_channel(px[R_LSB +: 8], b);
        res[B_LSB +: 8] = scale_channel(px[B_LSB +: 8], b);
        return res;
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Emits one WS2812 bit cell of TBIT cycles per accepted bit; a new bit is
// accepted when idle or on the last cycle of the current cell.
module ws2812_bit_encoder #(
    parameter int unsigned T0H  = 20,
    parameter int unsigned T1H  = 40,
    parameter int unsigned TBIT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    input  logic bit_value,
    output logic dout,
    output logic bit_last,
    output logic bit_prefetch
);

    localparam int unsigned CW = $clog2(TBIT);

    logic          active;
    logic          val;
    logic [CW-1:0] cnt;

    assign bit_last     = active && (cnt == CW'(TBIT - 1));
    assign bit_prefetch = active && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            val    <= 1'b0;
            cnt    <= '0;
            dout   <= 1'b0;
        end else if (bit_valid && (!active || bit_last)) begin
            active <= 1'b1;
            val    <= bit_value;
            cnt    <= '0;
            dout   <= 1'b1;
        end else if (active) begin
            if (bit_last) begin
                active <= 1'b0;
                dout   <= 1'b0;
            end else begin
                cnt  <= cnt + CW'(1);
                dout <= (cnt + CW'(1)) < (val ? CW'(T1H) : CW'(T0H));
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_streamer.sv
// Streams NUM_LEDS brightness-scaled GRB pixels from an external one-cycle
// latency pixel source onto a WS2812 data line, one-shot or continuously.
module ws2812_frame_streamer
    import ws2812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned T0H      = T0H_50M,
    parameter int unsigned T1H      = T1H_50M,
    parameter int unsigned TBIT     = TBIT_50M,
    parameter int unsigned TRESET   = TRESET_50M
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic continuous,
    input  logic [7:0] bright,
    output logic pix_req,
    output logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] pix_addr,
    input  logic [23:0] pix_data,
    output logic dout,
    output logic busy,
    output logic done
);

    localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned LW = (TRESET > 1) ? $clog2(TRESET) : 1;

    state_t        state;
    logic [7:0]    bright_q;
    logic [23:0]   sh;
    logic [23:0]   next_pix;
    logic [4:0]    bit_idx;
    logic [AW-1:0] pix_idx;
    logic [LW-1:0] lcnt;
    logic          cap_q;
    logic [23:0]   scaled;
    logic          last_pix;
    logic          bit_valid;
    logic          bit_value;
    logic          bit_last;
    logic          bit_prefetch;

    assign scaled   = scale_grb(pix_data, bright_q);
    assign last_pix = (pix_idx == AW'(NUM_LEDS - 1));

    // Next bit is offered on the last cycle of the running cell so cells abut
    always_comb begin
        bit_valid = 1'b0;
        bit_value = 1'b0;
        if (state == ST_WAIT) begin
            bit_valid = 1'b1;
            bit_value = scaled[23];
        end else if (state == ST_SEND && bit_last) begin
            if (bit_idx != 5'd0) begin
                bit_valid = 1'b1;
                bit_value = sh[bit_idx - 5'd1];
            end else if (!last_pix) begin
                bit_valid = 1'b1;
                bit_value = next_pix[23];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            bright_q <= '0;
            sh       <= '0;
            next_pix <= '0;
            bit_idx  <= '0;
            pix_idx  <= '0;
            lcnt     <= '0;
            cap_q    <= 1'b0;
            pix_req  <= 1'b0;
            pix_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            pix_req <= 1'b0;
            done    <= 1'b0;
            // Source answers one cycle after the strobe, i.e. the second cycle of bit 23
            cap_q   <= (state == ST_SEND) && pix_req && bit_prefetch;
            if (cap_q) next_pix <= scaled;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_PREFETCH;
                        bright_q <= bright;
                        busy     <= 1'b1;
                        pix_req  <= 1'b1;
                        pix_addr <= '0;
                    end
                end
                ST_PREFETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    sh      <= scaled;
                    bit_idx <= 5'd23;
                    pix_idx <= '0;
                    state   <= ST_SEND;
                    if (NUM_LEDS > 1) begin
                        pix_req  <= 1'b1;
                        pix_addr <= AW'(1);
                    end
                end
                ST_SEND: begin
                    if (bit_last) begin
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 5'd1;
                        end else if (last_pix) begin
                            state <= ST_LATCH;
                            lcnt  <= '0;
                        end else begin
                            sh      <= next_pix;
                            bit_idx <= 5'd23;
                            pix_idx <= pix_idx + AW'(1);
                            if ((32'(pix_idx) + 32'd2) < NUM_LEDS) begin
                                pix_req  <= 1'b1;
                                pix_addr <= pix_idx + AW'(2);
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (lcnt == LW'(TRESET - 1)) begin
                        done <= 1'b1;
                        if (continuous) begin
                            state    <= ST_PREFETCH;
                            bright_q <= bright;
                            pix_req  <= 1'b1;
                            pix_addr <= '0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        lcnt <= lcnt + LW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ws2812_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_enc (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .bit_value    (bit_value),
        .dout         (dout),
        .bit_last     (bit_last),
        .bit_prefetch (bit_prefetch)
    );

endmodule

// File: tb/tb_ws2812_frame_streamer.sv
// Bench for ws2812_frame_streamer: two instances (1 and 4 LEDs) checked cycle by
// cycle against an arithmetic model of the expected line waveform.
module tb_ws2812_frame_streamer;

    localparam int T0H    = 3;
    localparam int T1H    = 6;
    localparam int TBIT   = 10;
    localparam int TRESET = 20;

    logic        clk;
    logic        rst;
    logic        start1, start4;
    logic        continuous;
    logic [7:0]  bright;
    logic        pix_req1, pix_req4;
    logic [0:0]  pix_addr1;
    logic [1:0]  pix_addr4;
    logic [23:0] pix_data1, pix_data4;
    logic        dout1, dout4, busy1, busy4, done1, done4;

    logic [23:0] mem1;
    logic [23:0] mem4 [4];

    int tests = 0;
    int fails = 0;
    int sel_q = 0;

    logic       s_dout, s_req, s_done, s_busy;
    logic [1:0] s_addr;

    ws2812_frame_streamer #(
        .NUM_LEDS (1), .T0H (T0H), .T1H (T1H), .TBIT (TBIT), .TRESET (TRESET)
    ) dut1 (
        .clk (clk), .rst (rst), .start (start1), .continuous (continuous),
        .bright (bright), .pix_req (pix_req1), .pix_addr (pix_addr1),
        .pix_data (pix_data1), .dout (dout1), .busy (busy1), .done (done1)
    );

    ws2812_frame_streamer #(
        .NUM_LEDS (4), .T0H (T0H), .T1H (T1H), .TBIT (TBIT), .TRESET (TRESET)
    ) dut4 (
        .clk (clk), .rst (rst), .start (start4), .continuous (continuous),
        .bright (bright), .pix_req (pix_req4), .pix_addr (pix_addr4),
        .pix_data (pix_data4), .dout (dout4), .busy (busy4), .done (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pixel store: data valid only the cycle after a strobe, noise otherwise
    always @(posedge clk) begin
        pix_data1 <= pix_req1 ? mem1 : 24'($urandom);
        pix_data4 <= pix_req4 ? mem4[pix_addr4] : 24'($urandom);
    end

    always_comb begin
        s_dout = (sel_q != 0) ? dout4 : dout1;
        s_req  = (sel_q != 0) ? pix_req4 : pix_req1;
        s_done = (sel_q != 0) ? done4 : done1;
        s_busy = (sel_q != 0) ? busy4 : busy1;
        s_addr = (sel_q != 0) ? pix_addr4 : {1'b0, pix_addr1};
    end

    function automatic logic [23:0] model_scale(input logic [23:0] px, input logic [7:0] b);
        int g, r, bl;
        g  = (int'(px[23:16]) * (int'(b) + 1)) / 256;
        r  = (int'(px[15:8])  * (int'(b) + 1)) / 256;
        bl = (int'(px[7:0])   * (int'(b) + 1)) / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    task automatic run_frames(input int sel, input int nframes, input bit vary_bright,
                              input bit stray, input string tag,
                              output int hi_cnt, output int req_cnt);
        int nl, d, fl, total, drop_at, f, o, t, p, bi, c, done_cnt;
        int e_dout, e_req, e_addr, e_done, e_busy;
        int fb_dout, fb_req, fb_addr, fb_done, fb_busy;
        logic [7:0]  mbr;
        logic [23:0] px;
        logic x_dout, x_req, x_done, x_busy, bv;
        logic [1:0] x_addr;
        sel_q = sel;
        nl = (sel != 0) ? 4 : 1;
        d  = nl * 24 * TBIT;
        fl = 2 + d + TRESET;
        total = nframes * fl + 2;
        drop_at = (nframes - 1) * fl + int'($urandom_range(fl - 4, 1));
        e_dout = 0; e_req = 0; e_addr = 0; e_done = 0; e_busy = 0;
        fb_dout = -1; fb_req = -1; fb_addr = -1; fb_done = -1; fb_busy = -1;
        hi_cnt = 0; req_cnt = 0; done_cnt = 0;
        continuous = (nframes > 1);
        @(negedge clk);
        if (sel != 0) start4 = 1'b1; else start1 = 1'b1;
        mbr = bright;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            start4 = 1'b0;
            f = k / fl;
            o = k % fl;
            x_dout = 1'b0; x_req = 1'b0; x_addr = 2'd0;
            if (k >= nframes * fl) begin
                x_done = (o == 0);
                x_busy = 1'b0;
            end else begin
                x_done = (o == 0) && (f > 0);
                x_busy = 1'b1;
                if (o == 0) begin
                    x_req = 1'b1;
                end else if (o >= 2 && o < 2 + d) begin
                    t  = o - 2;
                    p  = t / (24 * TBIT);
                    bi = 23 - (t % (24 * TBIT)) / TBIT;
                    c  = t % TBIT;
                    px = model_scale((sel != 0) ? mem4[p] : mem1, mbr);
                    bv = px[bi];
                    x_dout = (c < (bv ? T1H : T0H));
                    if ((t % (24 * TBIT)) == 0 && p < nl - 1) begin
                        x_req  = 1'b1;
                        x_addr = 2'(p + 1);
                    end
                end
            end
            if (s_dout !== x_dout) begin e_dout++; if (fb_dout < 0) fb_dout = k; end
            if (s_req !== x_req) begin e_req++; if (fb_req < 0) fb_req = k; end
            if (x_req && s_addr !== x_addr) begin e_addr++; if (fb_addr < 0) fb_addr = k; end
            if (s_done !== x_done) begin e_done++; if (fb_done < 0) fb_done = k; end
            if (s_busy !== x_busy) begin e_busy++; if (fb_busy < 0) fb_busy = k; end
            if (s_dout === 1'b1) hi_cnt++;
            if (s_req === 1'b1) req_cnt++;
            if (s_done === 1'b1) done_cnt++;
            if (vary_bright && $urandom_range(15, 0) == 0) bright = 8'($urandom);
            if (stray && k == fl / 2) begin
                if (sel != 0) start4 = 1'b1; else start1 = 1'b1;
            end
            if (nframes > 1 && k == drop_at) continuous = 1'b0;
            if (((k + 1) % fl) == 0) mbr = bright;
        end
        continuous = 1'b0;
        tests++;
        if (e_dout !== 0) begin
            fails++;
            $display("FAIL %s dout: %0d bad cycles (first at cycle %0d), required 0", tag, e_dout, fb_dout);
        end
        tests++;
        if (e_req !== 0) begin
            fails++;
            $display("FAIL %s pix_req: %0d bad cycles (first at cycle %0d), required 0", tag, e_req, fb_req);
        end
        tests++;
        if (e_addr !== 0) begin
            fails++;
            $display("FAIL %s pix_addr: %0d bad fetches (first at cycle %0d), required 0", tag, e_addr, fb_addr);
        end
        tests++;
        if (e_done !== 0) begin
            fails++;
            $display("FAIL %s done: %0d bad cycles (first at cycle %0d), required 0", tag, e_done, fb_done);
        end
        tests++;
        if (e_busy !== 0) begin
            fails++;
            $display("FAIL %s busy: %0d bad cycles (first at cycle %0d), required 0", tag, e_busy, fb_busy);
        end
        tests++;
        if (done_cnt !== nframes) begin
            fails++;
            $display("FAIL %s done_count: got %0d, required %0d", tag, done_cnt, nframes);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start1 = 1'b0; start4 = 1'b0; continuous = 1'b0; bright = 8'd255;
        mem1 = '0;
        for (int i = 0; i < 4; i++) mem4[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({dout1, busy1, done1, pix_req1, pix_addr1} !== 5'b0) begin
            fails++;
            $display("FAIL reset_dut1: dout/busy/done/req/addr=%b, required 00000",
                     {dout1, busy1, done1, pix_req1, pix_addr1});
        end
        tests++;
        if ({dout4, busy4, done4, pix_req4, pix_addr4} !== 6'b0) begin
            fails++;
            $display("FAIL reset_dut4: dout/busy/done/req/addr=%b, required 000000",
                     {dout4, busy4, done4, pix_req4, pix_addr4});
        end
    endtask

    task automatic test_single_red();
        int hi, rq;
        mem1 = 24'h00FF00;
        bright = 8'd255;
        run_frames(0, 1, 1'b0, 1'b0, "single_red", hi, rq);
        tests++;
        if (hi !== 8 * T0H + 8 * T1H + 8 * T0H) begin
            fails++;
            $display("FAIL single_red_high_cycles: got %0d, required %0d", hi, 8 * T0H + 8 * T1H + 8 * T0H);
        end
    endtask

    task automatic test_prefetch();
        int hi, rq;
        for (int i = 0; i < 4; i++) mem4[i] = 24'($urandom);
        bright = 8'd255;
        run_frames(1, 1, 1'b0, 1'b0, "prefetch", hi, rq);
        tests++;
        if (rq !== 4) begin
            fails++;
            $display("FAIL prefetch_req_count: got %0d, required 4", rq);
        end
    endtask

    task automatic test_brightness();
        int hi, rq;
        mem1 = 24'hFFFFFF;
        bright = 8'd127;
        run_frames(0, 1, 1'b0, 1'b0, "bright127", hi, rq);
        tests++;
        if (hi !== 3 * (T0H + 7 * T1H)) begin
            fails++;
            $display("FAIL bright127_high_cycles: got %0d, required %0d", hi, 3 * (T0H + 7 * T1H));
        end
        bright = 8'd0;
        run_frames(0, 1, 1'b0, 1'b0, "bright0", hi, rq);
        tests++;
        if (hi !== 24 * T0H) begin
            fails++;
            $display("FAIL bright0_high_cycles: got %0d, required %0d", hi, 24 * T0H);
        end
        for (int i = 0; i < 4; i++) mem4[i] = 24'($urandom);
        bright = 8'($urandom);
        run_frames(1, 1, 1'b1, 1'b0, "bright_midframe", hi, rq);
    endtask

    task automatic test_continuous();
        int hi, rq;
        for (int i = 0; i < 4; i++) mem4[i] = 24'($urandom);
        bright = 8'($urandom);
        run_frames(1, 3, 1'b1, 1'b0, "continuous", hi, rq);
        tests++;
        if (rq !== 12) begin
            fails++;
            $display("FAIL continuous_req_count: got %0d, required 12", rq);
        end
    endtask

    task automatic test_stray_start();
        int hi, rq, extra;
        for (int i = 0; i < 4; i++) mem4[i] = 24'($urandom);
        bright = 8'($urandom);
        run_frames(1, 1, 1'b0, 1'b1, "stray_start", hi, rq);
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy4 !== 1'b0 || pix_req4 !== 1'b0) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL stray_start_idle: %0d active cycles after done, required 0", extra);
        end
    endtask

    task automatic test_reset_midframe();
        int n, seen_done, hi, rq;
        bit found;
        for (int i = 0; i < 4; i++) mem4[i] = 24'($urandom);
        bright = 8'd255;
        sel_q = 1;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (n >= 40 && dout4 === 1'b1) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL rst_precondition: dout never high within 200 cycles, required high");
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (dout4 !== 1'b0) begin
            fails++;
            $display("FAIL rst_async_dout: got %b before next edge, required 0", dout4);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done4 !== 1'b0 || busy4 !== 1'b0) seen_done++;
        end
        tests++;
        if (seen_done !== 0) begin
            fails++;
            $display("FAIL rst_abandon: %0d cycles with done/busy after reset, required 0", seen_done);
        end
        run_frames(1, 1, 1'b0, 1'b0, "after_reset", hi, rq);
    endtask

    initial begin
        test_reset();
        test_single_red();
        test_prefetch();
        test_brightness();
        test_continuous();
        test_stray_start();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
